// File: rtl/counter_seq_ctrl_if.sv
// Command handshake between a requester and counter_seq_ctrl.
// The requester drives the command fields. The controller returns CMD_READY and the DONE pulse.
interface counter_seq_ctrl_if #(
  parameter int LEN_W = 8
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [1:0]       CMD_OP;
  logic             CMD_DIR;
  logic [3:0]       CMD_VAL;
  logic [LEN_W-1:0] CMD_LEN;
  logic             DONE;

  modport master (
    output CMD_VALID, CMD_OP, CMD_DIR, CMD_VAL, CMD_LEN,
    input  CMD_READY, DONE
  );

  modport slave (
    input  CMD_VALID, CMD_OP, CMD_DIR, CMD_VAL, CMD_LEN,
    output CMD_READY, DONE
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Command sequencer for a 4-bit up/down counter that has no count enable.
// Define CNT_SEQ_CHECK_EN to build the Q/Qcc_n consistency checker that drives ERR.
module counter_seq_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic                CP,
  input  logic                RST,
  counter_seq_ctrl_if.slave   cmd,
  output logic                M,
  output logic [3:0]          D,
  output logic                LD_n,
  output logic                CLR_n,
  input  logic [3:0]          Q,
  input  logic                Qcc_n,
  output logic                ERR
);

  localparam int RW = (LEN_W > 4) ? LEN_W : 4;

  localparam logic [1:0] OP_CLEAR    = 2'b00;
  localparam logic [1:0] OP_LOAD     = 2'b01;
  localparam logic [1:0] OP_COUNT    = 2'b10;
  localparam logic [1:0] OP_COUNT_TC = 2'b11;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_CLR, S_LOAD, S_RUN} state_t;

  state_t        state, state_nxt;
  logic [3:0]    sh, sh_adv, tc_len, d_nxt;
  logic [RW-1:0] rem, rem_nxt;
  logic          accept, m_nxt, ld_n_nxt, clr_n_nxt, done_nxt;

  // sh_adv is the value the counter will hold after the coming edge, given the pins driven now.
  assign sh_adv = !CLR_n ? 4'd0 :
                  !LD_n  ? D    :
                  M      ? sh + 4'd1 : sh - 4'd1;

  assign cmd.CMD_READY = (state == S_IDLE);
  assign accept        = cmd.CMD_VALID && cmd.CMD_READY;
  assign tc_len        = cmd.CMD_DIR ? (4'd15 - sh) : sh;

  always_ff @(posedge CP) begin
    if (RST) begin
      state    <= S_INIT;
      M        <= 1'b1;
      D        <= 4'd0;
      LD_n     <= 1'b1;
      CLR_n    <= 1'b0;
      sh       <= 4'd0;
      rem      <= '0;
      cmd.DONE <= 1'b0;
    end else begin
      state    <= state_nxt;
      M        <= m_nxt;
      D        <= d_nxt;
      LD_n     <= ld_n_nxt;
      CLR_n    <= clr_n_nxt;
      sh       <= sh_adv;
      rem      <= rem_nxt;
      cmd.DONE <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT: state_nxt = S_IDLE;
      S_IDLE: begin
        if (accept) begin
          case (cmd.CMD_OP)
            OP_CLEAR:    state_nxt = S_CLR;
            OP_LOAD:     state_nxt = S_LOAD;
            OP_COUNT:    state_nxt = (cmd.CMD_LEN == '0) ? S_LOAD : S_RUN;
            OP_COUNT_TC: state_nxt = (tc_len == 4'd0) ? S_LOAD : S_RUN;
            default:     state_nxt = S_IDLE;
          endcase
        end
      end
      S_CLR, S_LOAD: state_nxt = S_IDLE;
      S_RUN:         state_nxt = (rem == RW'(1)) ? S_IDLE : S_RUN;
      default:       state_nxt = S_INIT;
    endcase
  end

  // Pin values follow the state being entered, so they change on the same edge as the state.
  always_comb begin
    m_nxt     = M;
    d_nxt     = sh_adv;
    ld_n_nxt  = 1'b0;
    clr_n_nxt = 1'b1;
    done_nxt  = 1'b0;
    rem_nxt   = rem;
    case (state_nxt)
      S_CLR: begin
        clr_n_nxt = 1'b0;
        ld_n_nxt  = 1'b1;
      end
      S_LOAD: begin
        if (cmd.CMD_OP == OP_LOAD)
          d_nxt = cmd.CMD_VAL;
      end
      S_RUN: begin
        ld_n_nxt = 1'b1;
        if (state == S_IDLE) begin
          m_nxt   = cmd.CMD_DIR;
          rem_nxt = (cmd.CMD_OP == OP_COUNT) ? RW'(cmd.CMD_LEN) : RW'(tc_len);
        end else begin
          rem_nxt = rem - RW'(1);
        end
      end
      S_IDLE: begin
        done_nxt = (state == S_CLR) || (state == S_LOAD) || (state == S_RUN);
      end
      default: begin
        clr_n_nxt = 1'b0;
        ld_n_nxt  = 1'b1;
        m_nxt     = 1'b1;
        d_nxt     = 4'd0;
      end
    endcase
  end

`ifdef CNT_SEQ_CHECK_EN
  logic armed, mismatch;

  assign mismatch = (Q != sh) ||
                    (Qcc_n != !((M && (Q == 4'd15)) || (!M && (Q == 4'd0))));

  // armed skips the first cycle after INIT, before the shadow has been proven against the counter.
  always_ff @(posedge CP) begin
    if (RST) begin
      armed <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      armed <= (state != S_INIT);
      if (armed && (state != S_INIT) && mismatch)
        ERR <= 1'b1;
    end
  end
`else
  logic unused_pins;
  assign unused_pins = ^{Q, Qcc_n};
  assign ERR         = 1'b0;
`endif

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench: models the external up/down counter and predicts results from command semantics.
module tb_counter_seq_ctrl;
  localparam int LEN_W = 8;
`ifdef CNT_SEQ_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       M, LD_n, CLR_n, Qcc_n, ERR;
  logic [3:0] D, Q, q_cnt, q_ovr;
  logic       ovr_en;
  int         checks = 0;
  int         fails  = 0;
  int         ref_q  = 0;
  int         lat;

  always #5 clk = ~clk;

  counter_seq_ctrl_if #(.LEN_W(LEN_W)) bus ();

  counter_seq_ctrl #(.LEN_W(LEN_W)) dut (
    .CP(clk), .RST(rst), .cmd(bus), .M(M), .D(D), .LD_n(LD_n),
    .CLR_n(CLR_n), .Q(Q), .Qcc_n(Qcc_n), .ERR(ERR)
  );

  // External counter: clear beats load, otherwise it counts on every edge.
  always @(posedge clk) begin
    if (!CLR_n)     q_cnt <= 4'd0;
    else if (!LD_n) q_cnt <= D;
    else if (M)     q_cnt <= q_cnt + 4'd1;
    else            q_cnt <= q_cnt - 4'd1;
  end
  assign Q     = ovr_en ? q_ovr : q_cnt;
  assign Qcc_n = !((M && (Q == 4'd15)) || (!M && (Q == 4'd0)));

  function automatic int model_q(int op, int dir, int val, int len, int q);
    case (op)
      0:       return 0;
      1:       return val;
      2:       return dir ? (q + len) % 16 : (((q - len) % 16) + 16) % 16;
      default: return dir ? 15 : 0;
    endcase
  endfunction

  function automatic int model_lat(int op, int dir, int len, int q);
    int l;
    case (op)
      2:       l = len;
      3:       l = dir ? 15 - q : q;
      default: l = 1;
    endcase
    return (l == 0) ? 1 : l;
  endfunction

  // Present a command at a falling edge, then count edges until DONE (bounded).
  task automatic apply_stimulus(input int op, input int dir, input int val, input int len);
    bus.CMD_VALID = 1'b1;
    bus.CMD_OP    = 2'(op);
    bus.CMD_DIR   = 1'(dir);
    bus.CMD_VAL   = 4'(val);
    bus.CMD_LEN   = LEN_W'(len);
    @(posedge clk);
    @(negedge clk);
    bus.CMD_VALID = 1'b0;
    bus.CMD_OP    = 2'($urandom);
    bus.CMD_DIR   = 1'($urandom);
    bus.CMD_VAL   = 4'($urandom);
    bus.CMD_LEN   = LEN_W'($urandom);
    lat = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end while (!bus.DONE && lat < 400);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (CLR_n !== 1'b0) begin fails++; $display("[TB] FAIL reset_clr_n: got %b expected 0", CLR_n); end
    checks++; if (Q !== 4'd0) begin fails++; $display("[TB] FAIL reset_q: got %0h expected 0", Q); end
    checks++; if (bus.CMD_READY !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 0", bus.CMD_READY); end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.CMD_READY !== 1'b1) begin fails++; $display("[TB] FAIL release_ready: got %b expected 1", bus.CMD_READY); end
    checks++; if (bus.DONE !== 1'b0 || ERR !== 1'b0) begin fails++; $display("[TB] FAIL release_done_err: got %b%b expected 00", bus.DONE, ERR); end
    checks++; if (Q !== 4'd0) begin fails++; $display("[TB] FAIL release_q: got %0h expected 0", Q); end
    ref_q = 0;
  endtask

  task automatic test_load_count();
    apply_stimulus(1, 0, 7, 0);
    checks++; if (lat !== 1 || Q !== 4'd7) begin fails++; $display("[TB] FAIL load7: got lat %0d q %0h expected lat 1 q 7", lat, Q); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (Q !== 4'd7 || bus.DONE !== 1'b0) begin fails++; $display("[TB] FAIL hold7: got q %0h done %b expected q 7 done 0", Q, bus.DONE); end
    end
    apply_stimulus(2, 1, 0, 5);
    checks++; if (lat !== 5 || Q !== 4'hC) begin fails++; $display("[TB] FAIL count_up5: got lat %0d q %0h expected lat 5 q c", lat, Q); end
    checks++; if (LD_n !== 1'b0) begin fails++; $display("[TB] FAIL count_up5_ld_n: got %b expected 0", LD_n); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.DONE !== 1'b0 || Q !== 4'hC) begin fails++; $display("[TB] FAIL done_pulse: got done %b q %0h expected done 0 q c", bus.DONE, Q); end
    ref_q = 12;
  endtask

  task automatic test_count_wrap();
    apply_stimulus(1, 0, 2, 0);
    apply_stimulus(2, 0, 0, 20);
    checks++; if (lat !== 20 || Q !== 4'hE) begin fails++; $display("[TB] FAIL count_down20: got lat %0d q %0h expected lat 20 q e", lat, Q); end
    checks++; if (ERR !== 1'b0) begin fails++; $display("[TB] FAIL wrap_err: got %b expected 0", ERR); end
    ref_q = 14;
  endtask

  task automatic test_count_tc();
    apply_stimulus(1, 0, 9, 0);
    apply_stimulus(3, 1, 0, 0);
    checks++; if (lat !== 6 || Q !== 4'hF) begin fails++; $display("[TB] FAIL tc_up: got lat %0d q %0h expected lat 6 q f", lat, Q); end
    checks++; if (Qcc_n !== 1'b0) begin fails++; $display("[TB] FAIL tc_qcc_n: got %b expected 0", Qcc_n); end
    apply_stimulus(3, 1, 0, 0);
    checks++; if (lat !== 1 || Q !== 4'hF) begin fails++; $display("[TB] FAIL tc_zero: got lat %0d q %0h expected lat 1 q f", lat, Q); end
    ref_q = 15;
  endtask

  task automatic test_reset_mid_run();
    apply_stimulus(0, 0, 0, 0);
    checks++; if (lat !== 1 || Q !== 4'd0) begin fails++; $display("[TB] FAIL clear: got lat %0d q %0h expected lat 1 q 0", lat, Q); end
    bus.CMD_VALID = 1'b1;
    bus.CMD_OP    = 2'd2;
    bus.CMD_DIR   = 1'b1;
    bus.CMD_LEN   = LEN_W'(10);
    @(posedge clk);
    @(negedge clk);
    bus.CMD_VALID = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (CLR_n !== 1'b0 || bus.DONE !== 1'b0) begin fails++; $display("[TB] FAIL abort_pins: got clr_n %b done %b expected 0 0", CLR_n, bus.DONE); end
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++; if (Q !== 4'd0 || bus.DONE !== 1'b0) begin fails++; $display("[TB] FAIL abort_idle: got q %0h done %b expected q 0 done 0", Q, bus.DONE); end
    end
    apply_stimulus(1, 0, 3, 0);
    checks++; if (lat !== 1 || Q !== 4'd3) begin fails++; $display("[TB] FAIL load3_after_abort: got lat %0d q %0h expected lat 1 q 3", lat, Q); end
    ref_q = 3;
  endtask

  task automatic test_err();
    apply_stimulus(1, 0, 4, 0);
    q_ovr  = 4'd5;
    ovr_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ovr_en = 1'b0;
    checks++; if (ERR !== ERR_EXP) begin fails++; $display("[TB] FAIL err_rise: got %b expected %b", ERR, ERR_EXP); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (ERR !== ERR_EXP) begin fails++; $display("[TB] FAIL err_sticky: got %b expected %b", ERR, ERR_EXP); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (ERR !== 1'b0 || Q !== 4'd0) begin fails++; $display("[TB] FAIL err_cleared: got err %b q %0h expected err 0 q 0", ERR, Q); end
    ref_q = 0;
  endtask

  task automatic test_back_to_back();
    int op, dir, val, len, exp_q, exp_lat;
    for (int i = 0; i < 30; i++) begin
      op  = $urandom_range(0, 3);
      dir = $urandom_range(0, 1);
      val = $urandom_range(0, 15);
      len = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 40);
      exp_q   = model_q(op, dir, val, len, ref_q);
      exp_lat = model_lat(op, dir, len, ref_q);
      checks++; if (bus.CMD_READY !== 1'b1) begin fails++; $display("[TB] FAIL b2b_ready: got %b expected 1", bus.CMD_READY); end
      apply_stimulus(op, dir, val, len);
      checks++; if (lat !== exp_lat || Q !== 4'(exp_q)) begin
        fails++;
        $display("[TB] FAIL b2b_cmd%0d op%0d: got lat %0d q %0h expected lat %0d q %0h", i, op, lat, Q, exp_lat, exp_q);
      end
      ref_q = exp_q;
    end
    checks++; if (ERR !== 1'b0) begin fails++; $display("[TB] FAIL b2b_err: got %b expected 0", ERR); end
  endtask

  initial begin
    rst           = 1'b1;
    ovr_en        = 1'b0;
    q_ovr         = 4'd0;
    bus.CMD_VALID = 1'b0;
    bus.CMD_OP    = 2'd0;
    bus.CMD_DIR   = 1'b0;
    bus.CMD_VAL   = 4'd0;
    bus.CMD_LEN   = '0;
    test_reset();
    test_load_count();
    test_count_wrap();
    test_count_tc();
    test_reset_mid_run();
    test_err();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Command-driven sequencer for the 4-bit up/down binary counter (CP, M, D, LD_n, CLR_n, Q, Qcc_n).
- Accepts clear, load, count-N and count-to-terminal commands over a valid/ready handshake and drives the counter's control pins cycle-accurately.
- Between commands it freezes the counter by continuous self-reload, since the counter has no count enable.
- Keeps a shadow copy of the counter value for stop prediction and, optionally, for consistency checking.

## Interface
Parameters:
- LEN_W, 8, width of the count-length field; N ranges 0..2^LEN_W-1

Ports:
- CP  in  1  clock, rising edge; same clock as the counter
- RST  in  1  reset; one clock, reset is synchronous and active-high
- CMD_VALID  in  1  command present
- CMD_READY  out  1  controller accepts a command this cycle
- CMD_OP  in  2  00 CLEAR, 01 LOAD, 10 COUNT, 11 COUNT_TC
- CMD_DIR  in  1  1 = up, 0 = down (COUNT, COUNT_TC)
- CMD_VAL  in  4  load value (LOAD)
- CMD_LEN  in  LEN_W  number of count edges (COUNT)
- M  out  1  counter direction, registered
- D  out  4  counter parallel data, registered
- LD_n  out  1  counter load, active low, registered
- CLR_n  out  1  counter clear, active low, registered
- Q  in  4  counter output
- Qcc_n  in  1  counter terminal-count flag, active low
- DONE  out  1  one-cycle pulse: command complete
- ERR  out  1  sticky mismatch flag (see Configuration)

## Operation
- Counter contract: clear and load are synchronous on CP, with clear having priority; otherwise the counter counts every edge, with M=1 up and M=0 down. Qcc_n is low at Q=15 when M=1 and at Q=0 when M=0.
- Shadow register SH is the value the counter holds after the current edge:
  - computed from the registered outputs currently driven (CLR_n → 0; else LD_n=0 → D; else ±1 mod 16);
  - so Q == SH in every cycle after the first post-reset edge.
- States: INIT, IDLE, CLR, LOAD, RUN.
- INIT (reset state):
  - outputs CLR_n=0, LD_n=1, M=1, D=0; SH=0, DONE=0, remaining=0, CMD_READY=0;
  - exits to IDLE on the first edge with RST low.
- IDLE (hold):
  - CLR_n=1, LD_n=0, D=SH, M unchanged;
  - CMD_READY=1, combinationally (state==IDLE);
  - accepts a command on an edge with CMD_VALID & CMD_READY.
- CLEAR: CLR→ drive CLR_n=0, LD_n=1 for one cycle; SH→0; return to IDLE.
- LOAD: drive LD_n=0, D=CMD_VAL for one cycle; SH→CMD_VAL; return to IDLE.
- COUNT:
  - if CMD_LEN=0, behaves as LOAD of SH (no count);
  - otherwise RUN with LD_n=1 and M=CMD_DIR for exactly CMD_LEN cycles, so the counter advances CMD_LEN times mod 16; then IDLE.
- COUNT_TC:
  - length L = CMD_DIR ? 15−SH : SH, computed at accept;
  - L=0 is a one-cycle no-op; otherwise identical to COUNT with length L;
  - the counter stops exactly on the terminal value, with no overshoot.
- DONE is registered and asserted in the first IDLE cycle after any command.
- Back-to-back commands are allowed: CMD_READY=1 in the DONE cycle.
- RST high at any edge, including mid-RUN:
  - forces INIT values and aborts the command;
  - no DONE is issued for the aborted command;
  - the counter is cleared on the next edge.
- CMD fields are sampled only on the accept edge; changes afterwards are ignored.

## Timing
- Command accepted at edge e0; control outputs change at e0; the counter acts at e1.
- CLEAR and LOAD: counter updated at e1; DONE high in the cycle after e1. Latency is 1 cycle.
- COUNT N (N≥1): counter advances at e1..eN; LD_n returns to 0 at eN; DONE in the cycle after eN, with Q = start ± N.
- COUNT_TC: same timing as COUNT with N = L.
- Zero-length COUNT and COUNT_TC: DONE after e1.
- Maximum throughput: one command per 1+N cycles.

## Configuration
- Macro CNT_SEQ_CHECK_EN.
- Defined:
  - every cycle except INIT and the first cycle after INIT, compare Q against SH;
  - also compare Qcc_n against ~((M&&Q==15)||(!M&&Q==0));
  - any mismatch sets ERR on the next edge; ERR clears only by RST.
- Undefined: ERR tied 0; no comparators synthesized; all other behaviour identical.

## Test plan
- Reset: RST high 3 cycles, then low → CLR_n=0 during reset, Q=0, CMD_READY=1 one cycle after release, DONE=0, ERR=0.
- LOAD 4'h7 then COUNT up N=5 → Q=7 held for ≥3 idle cycles, then Q=C after 5 edges, DONE single pulse, LD_n low again.
- LOAD 4'h2, COUNT down N=20 → wraps through 0; final Q=4'hE (2−20 mod 16); no ERR.
- LOAD 4'h9, COUNT_TC up → exactly 6 edges, Q=F, Qcc_n low; repeat COUNT_TC up → zero-length, DONE after 1 cycle, Q stays F.
- RST asserted during the 3rd cycle of COUNT up N=10 from Q=0 → no DONE, Q=0 after the next edge, SH=0; next LOAD 4'h3 works normally.
- With CNT_SEQ_CHECK_EN, force Q to 4'h5 while SH=4'h4 → ERR rises the next edge and stays high until RST; without the macro, ERR stays 0.
